// File: rtl/adpcm_multi_if.sv
// rtl/adpcm_multi_if.sv - request/result bundle between the sample FIFOs and the multi-channel ADPCM codec
//
// Purpose: groups every codec signal except clk/rstn.
// master: drives enable, req (toggle), ch, sel_rx, rx_pcm, rx_adpcm, clr;
//         observes ack, tx_pcm, tx_adpcm, tx_ch, err, cst.
// slave : the codec side (directions mirrored).
interface adpcm_multi_if #(
    parameter int NCH = 2
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                  enable;
    logic                  req;
    logic                  ack;
    logic [CHW-1:0]        ch;
    logic                  sel_rx;
    logic signed [15:0]    rx_pcm;
    logic [3:0]            rx_adpcm;
    logic                  clr;
    logic signed [15:0]    tx_pcm;
    logic [3:0]            tx_adpcm;
    logic [CHW-1:0]        tx_ch;
    logic                  err;
    logic [2:0]            cst;

    modport master (
        output enable, req, ch, sel_rx, rx_pcm, rx_adpcm, clr,
        input  ack, tx_pcm, tx_adpcm, tx_ch, err, cst
    );

    modport slave (
        input  enable, req, ch, sel_rx, rx_pcm, rx_adpcm, clr,
        output ack, tx_pcm, tx_adpcm, tx_ch, err, cst
    );
endinterface

// File: rtl/adpcm_multi.sv
// rtl/adpcm_multi.sv - time-multiplexed IMA-ADPCM encoder/decoder for NCH channels
//
// Purpose: one bit-serial datapath converts one sample per req toggle, either
// 16-bit PCM -> 4-bit code (sel_rx=0) or 4-bit code -> 16-bit PCM (sel_rx=1),
// using the predictor and step index of the requested channel.
// Ports: clk, rstn (async active-low); bus (slave modport of adpcm_multi_if):
//   enable, req, ch, sel_rx, rx_pcm, rx_adpcm, clr in;
//   ack, tx_pcm, tx_adpcm, tx_ch, err, cst out.
module adpcm_multi #(
    parameter int NCH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    adpcm_multi_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    // State encodings are the Gray codes of 0..7, so cst is the state register itself.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_B3   = 3'b011,
        S_B2   = 3'b010,
        S_B1   = 3'b110,
        S_B0   = 3'b111,
        S_UPD  = 3'b101,
        S_STEP = 3'b100
    } state_t;

    localparam logic [14:0] STEP_TABLE [0:88] = '{
        15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
        15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
        15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
        15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
        15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
        15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
        15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
        15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
        15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
        15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
        15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
        15'd32767
    };

    state_t              state;
    logic                req_d;
    logic                req_x;
    logic signed [15:0]  predict [NCH];
    logic [6:0]          idx [NCH];

    logic [CHW-1:0]      ch_r;
    logic                mode_r;
    logic                sign_r;
    logic [3:0]          code_r;
    logic signed [15:0]  pcm_r;
    logic [14:0]         step_r;
    logic [16:0]         sigma_r;
    logic [16:0]         diff_r;

    logic                ack_r;
    logic                err_r;
    logic signed [15:0]  tx_pcm_r;
    logic [3:0]          tx_adpcm_r;
    logic [CHW-1:0]      tx_ch_r;

    logic signed [16:0]  diff_s;
    logic [16:0]         diff_abs;
    logic [14:0]         step_lu;
    logic [1:0]          bit_k;
    logic                take;
    logic signed [17:0]  pred_sum;
    logic signed [15:0]  pred_sat;
    logic signed [4:0]   idx_adj;
    logic signed [7:0]   idx_sum;
    logic [6:0]          idx_new;

    assign req_x    = bus.req ^ req_d;
    assign step_lu  = STEP_TABLE[idx[ch_r]];
    assign diff_s   = $signed({pcm_r[15], pcm_r}) - $signed({predict[ch_r][15], predict[ch_r]});
    assign diff_abs = diff_s[16] ? $unsigned(-diff_s) : $unsigned(diff_s);

    // Code bit handled by the current bit-serial cycle; encode compares the
    // residual, decode simply reads the incoming code bit.
    always_comb begin
        bit_k = 2'd0;
        case (state)
            S_B2:    bit_k = 2'd2;
            S_B1:    bit_k = 2'd1;
            default: bit_k = 2'd0;
        endcase
        take = mode_r ? code_r[bit_k] : (diff_r >= 17'(step_r));
    end

    // 18 bits so that predict +/- sigma (sigma up to 61436) cannot wrap before clamping.
    always_comb begin
        pred_sum = sign_r ? (18'(predict[ch_r]) - $signed({1'b0, sigma_r}))
                          : (18'(predict[ch_r]) + $signed({1'b0, sigma_r}));
        if (pred_sum > 18'sd32767)
            pred_sat = 16'sh7fff;
        else if (pred_sum < -18'sd32768)
            pred_sat = 16'sh8000;
        else
            pred_sat = pred_sum[15:0];
    end

    always_comb begin
        case (code_r[2:0])
            3'd4:    idx_adj = 5'sd2;
            3'd5:    idx_adj = 5'sd4;
            3'd6:    idx_adj = 5'sd6;
            3'd7:    idx_adj = 5'sd8;
            default: idx_adj = -5'sd1;
        endcase
        idx_sum = $signed({1'b0, idx[ch_r]}) + 8'(idx_adj);
        if (idx_sum < 8'sd0)
            idx_new = 7'd0;
        else if (idx_sum > 8'sd88)
            idx_new = 7'd88;
        else
            idx_new = idx_sum[6:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            req_d      <= 1'b0;
            ack_r      <= 1'b1;
            err_r      <= 1'b0;
            tx_pcm_r   <= '0;
            tx_adpcm_r <= '0;
            tx_ch_r    <= '0;
            ch_r       <= '0;
            mode_r     <= 1'b0;
            sign_r     <= 1'b0;
            code_r     <= '0;
            pcm_r      <= '0;
            step_r     <= '0;
            sigma_r    <= '0;
            diff_r     <= '0;
            for (int i = 0; i < NCH; i++) begin
                predict[i] <= '0;
                idx[i]     <= '0;
            end
        end else if (!bus.enable) begin
            // req_d deliberately holds so a toggle made while disabled is seen later.
            state      <= S_IDLE;
            ack_r      <= 1'b1;
            err_r      <= 1'b0;
            tx_pcm_r   <= '0;
            tx_adpcm_r <= '0;
            tx_ch_r    <= '0;
            for (int i = 0; i < NCH; i++) begin
                predict[i] <= '0;
                idx[i]     <= '0;
            end
        end else begin
            req_d <= bus.req;
            case (state)
                S_IDLE: begin
                    if (bus.clr) begin
                        err_r <= 1'b0;
                        for (int i = 0; i < NCH; i++) begin
                            predict[i] <= '0;
                            idx[i]     <= '0;
                        end
                    end else if (req_x) begin
                        if (32'(bus.ch) >= NCH) begin
                            err_r <= 1'b1;
                        end else begin
                            ch_r   <= bus.ch;
                            mode_r <= bus.sel_rx;
                            pcm_r  <= bus.rx_pcm;
                            code_r <= bus.sel_rx ? bus.rx_adpcm : 4'd0;
                            state  <= S_LOAD;
                            ack_r  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    step_r  <= step_lu;
                    sigma_r <= 17'(step_lu >> 3);
                    if (mode_r) begin
                        sign_r <= code_r[3];
                    end else begin
                        sign_r <= diff_s[16];
                        diff_r <= diff_abs;
                    end
                    state <= S_B3;
                end
                S_B3: begin
                    code_r[3] <= sign_r;
                    state     <= S_B2;
                end
                S_B2, S_B1, S_B0: begin
                    if (take) begin
                        sigma_r <= sigma_r + 17'(step_r);
                        if (!mode_r) begin
                            code_r[bit_k] <= 1'b1;
                            diff_r        <= diff_r - 17'(step_r);
                        end
                    end
                    step_r <= step_r >> 1;
                    state  <= (state == S_B2) ? S_B1 : ((state == S_B1) ? S_B0 : S_UPD);
                end
                S_UPD: begin
                    predict[ch_r] <= pred_sat;
                    idx[ch_r]     <= idx_new;
                    state         <= S_STEP;
                end
                S_STEP: begin
                    if (mode_r)
                        tx_pcm_r <= predict[ch_r];
                    else
                        tx_adpcm_r <= code_r;
                    tx_ch_r <= ch_r;
                    ack_r   <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            // A toggle arriving while busy is lost; flag it without touching the conversion.
            if (req_x && (state != S_IDLE))
                err_r <= 1'b1;
        end
    end

    assign bus.ack      = ack_r;
    assign bus.err      = err_r;
    assign bus.tx_pcm   = tx_pcm_r;
    assign bus.tx_adpcm = tx_adpcm_r;
    assign bus.tx_ch    = tx_ch_r;
    assign bus.cst      = state;
endmodule
